// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder that steps one shared full_adder cell LSB-first.
module full_adder (
   input  logic Ain,
   input  logic Bin,
   input  logic Cin,
   output logic Sout,
   output logic Cout
);
   assign Sout = Ain ^ Bin ^ Cin;
   assign Cout = (Ain & Bin) | (Cin & (Ain ^ Bin));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             Cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum_out,
   output logic             Cout_out,
   output logic             Ovf_out
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic [CW-1:0] count;
   logic carry, s, c;
   full_adder fa (.Ain(a_sh[0]), .Bin(b_sh[0]), .Cin(carry), .Sout(s), .Cout(c));
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         r_sh     <= '0;
         carry    <= 1'b0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Sum_out  <= '0;
         Cout_out <= 1'b0;
         Ovf_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_sh  <= A_in;
               b_sh  <= B_in;
               carry <= Cin_in;
               r_sh  <= '0;
               count <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               r_sh  <= {s, r_sh[WIDTH-1:1]};
               carry <= c;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               count <= count + 1'b1;
               // carry still holds the carry into the MSB on the final step
               if (count == LAST) begin
                  Sum_out  <= {s, r_sh[WIDTH-1:1]};
                  Cout_out <= c;
                  Ovf_out  <= carry ^ c;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
